// File: rtl/pn_checker_if.sv
// Receive-side bit stream into the PN checker: one data bit plus its
// qualifier. The source side (serialiser or bench) uses the master modport,
// the checker uses the slave modport.
interface pn_checker_if;
  logic rx_bit;
  logic rx_valid;

  modport master (output rx_bit, output rx_valid);
  modport slave  (input  rx_bit, input  rx_valid);
endinterface

// File: rtl/pn_checker.sv
// Serial PN-sequence checker.
// It refills a shadow copy of the generator state from the received bits
// until LOCK_CNT consecutive predictions match. After that the copy
// free-runs on its own predictions, and mismatches are counted as bit errors.
// Too many errors inside one WIN_LEN-bit window drops lock and restarts the
// search.
module pn_checker #(
  parameter int             N         = 4,
  parameter logic [N-1:0]   TAP_MASK  = 4'b1100,
  parameter int             LOCK_CNT  = 8,
  parameter int             WIN_LEN   = 16,
  parameter int             ERR_LIMIT = 4,
  parameter int             CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  pn_checker_if.slave       rx,
  input  logic              clr_cnt,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int FW = $clog2(N + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int EW = $clog2(ERR_LIMIT + 1);

  typedef enum logic [0:0] {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state_q;
  logic [N-1:0]    sh_q;
  logic [FW-1:0]   fill_q;
  logic [MW-1:0]   match_q;
  logic [WW-1:0]   win_cnt_q;
  logic [EW-1:0]   win_err_q;

  logic            pred_s;
  logic            err_s;
  logic            hit_s;
  logic            lose_s;
  logic            win_last_s;
  logic            cnt_en_s;
  logic [CNT_W-1:0] err_count_d;
  logic [CNT_W-1:0] bit_count_d;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // The prediction is the generator feedback computed from the shadow state.
  // A match against an all-zero shadow is not accepted as a hit, because an
  // all-zero stream would otherwise lock.
  assign pred_s     = ^(sh_q & TAP_MASK);
  assign err_s      = rx.rx_bit ^ pred_s;
  assign hit_s      = ~err_s & (sh_q != {N{1'b0}});
  assign lose_s     = err_s & ((win_err_q + {{(EW-1){1'b0}}, 1'b1}) == EW'(ERR_LIMIT));
  assign win_last_s = (win_cnt_q == WW'(WIN_LEN - 1));
  assign cnt_en_s   = rx.rx_valid & (state_q == LOCKED);

  // Statistics next-state: a clear wins over any increment on the same cycle.
  always_comb begin
    err_count_d = err_count;
    bit_count_d = bit_count;
    if (clr_cnt) begin
      err_count_d = {CNT_W{1'b0}};
      bit_count_d = {CNT_W{1'b0}};
    end else if (cnt_en_s) begin
      bit_count_d = sat_inc(bit_count);
      if (err_s) begin
        err_count_d = sat_inc(err_count);
      end else begin
        err_count_d = err_count;
      end
    end else begin
      err_count_d = err_count;
      bit_count_d = bit_count;
    end
  end

  // Lock FSM, shadow register, window tracking and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SEARCH;
      sh_q      <= {N{1'b0}};
      fill_q    <= {FW{1'b0}};
      match_q   <= {MW{1'b0}};
      win_cnt_q <= {WW{1'b0}};
      win_err_q <= {EW{1'b0}};
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= {CNT_W{1'b0}};
      bit_count <= {CNT_W{1'b0}};
    end else begin
      err_pulse <= 1'b0;
      err_count <= err_count_d;
      bit_count <= bit_count_d;
      if (rx.rx_valid) begin
        case (state_q)
          SEARCH: begin
            sh_q <= {sh_q[N-2:0], rx.rx_bit};
            if (fill_q != FW'(N)) begin
              fill_q <= fill_q + {{(FW-1){1'b0}}, 1'b1};
            end else if (hit_s) begin
              if (match_q == MW'(LOCK_CNT - 1)) begin
                state_q   <= LOCKED;
                locked    <= 1'b1;
                match_q   <= {MW{1'b0}};
                win_cnt_q <= {WW{1'b0}};
                win_err_q <= {EW{1'b0}};
              end else begin
                match_q <= match_q + {{(MW-1){1'b0}}, 1'b1};
              end
            end else begin
              match_q <= {MW{1'b0}};
            end
          end
          LOCKED: begin
            // Replica free-runs on its own prediction, not on the received bit.
            sh_q      <= {sh_q[N-2:0], pred_s};
            err_pulse <= err_s;
            if (lose_s) begin
              state_q <= SEARCH;
              locked  <= 1'b0;
              fill_q  <= {FW{1'b0}};
              match_q <= {MW{1'b0}};
            end else if (win_last_s) begin
              win_cnt_q <= {WW{1'b0}};
              win_err_q <= {EW{1'b0}};
            end else begin
              win_cnt_q <= win_cnt_q + {{(WW-1){1'b0}}, 1'b1};
              win_err_q <= win_err_q + {{(EW-1){1'b0}}, err_s};
            end
          end
          default: begin
            state_q <= SEARCH;
            locked  <= 1'b0;
          end
        endcase
      end else begin
        sh_q <= sh_q;
      end
    end
  end

endmodule

// File: tb/tb_pn_checker.sv
// Directed bench for pn_checker. A reference model pushes the expected
// outputs for every driven cycle into a scoreboard queue. The entry is popped
// and compared once the DUT has clocked that cycle. Milestone checks against
// fixed constants are placed at the points of interest.
module tb_pn_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr_cnt;
  logic        locked, err_pulse, locked4, err_pulse4;
  logic [15:0] err_count, bit_count;
  logic [3:0]  err_count4, bit_count4;

  pn_checker_if rx ();

  always #5 clk = ~clk;

  pn_checker #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .bit_count(bit_count)
  );

  pn_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .rx(rx), .clr_cnt(clr_cnt),
    .locked(locked4), .err_pulse(err_pulse4),
    .err_count(err_count4), .bit_count(bit_count4)
  );

  typedef struct {
    logic        lock;
    logic        pulse;
    logic [15:0] errc;
    logic [15:0] bitc;
    logic [3:0]  errc4;
    logic [3:0]  bitc4;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic       m_lock, m_pulse;
  logic [3:0] m_sh;
  int         m_fill, m_match, m_win, m_werr, m_errc, m_bitc, m_errc4, m_bitc4;

  logic [14:0] pn_tbl;
  int          ph;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = 1'b0; m_pulse = 1'b0; m_sh = 4'd0;
    m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
    m_errc = 0; m_bitc = 0; m_errc4 = 0; m_bitc4 = 0;
  endtask

  task automatic model_step(input logic v, input logic b, input logic c);
    logic       pred, err;
    logic [3:0] sh0;
    m_pulse = 1'b0;
    if (v) begin
      sh0  = m_sh;
      pred = ^(sh0 & 4'b1100);
      m_sh = {sh0[2:0], (m_lock ? pred : b)};
      if (!m_lock) begin
        if (m_fill < 4) m_fill++;
        else if ((b == pred) && (sh0 != 4'd0)) begin
          m_match++;
          if (m_match == 8) begin
            m_lock = 1'b1; m_match = 0; m_win = 0; m_werr = 0;
          end
        end else m_match = 0;
      end else begin
        err = (b != pred);
        m_pulse = err;
        if (!c) begin
          if (m_bitc < 65535) m_bitc++;
          if (m_bitc4 < 15) m_bitc4++;
          if (err && m_errc < 65535) m_errc++;
          if (err && m_errc4 < 15) m_errc4++;
        end
        if (err && (m_werr + 1 >= 4)) begin
          m_lock = 1'b0; m_fill = 0; m_match = 0;
        end else begin
          m_werr += int'(err);
          if (m_win == 15) begin m_win = 0; m_werr = 0; end
          else m_win++;
        end
      end
    end
    if (c) begin
      m_errc = 0; m_bitc = 0; m_errc4 = 0; m_bitc4 = 0;
    end
  endtask

  // Drive one cycle, push the model's expectation, clock, then pop and compare.
  task automatic step(input logic v, input logic b, input logic c);
    exp_t e;
    rx.rx_valid = v; rx.rx_bit = b; clr_cnt = c;
    model_step(v, b, c);
    e.lock = m_lock; e.pulse = m_pulse;
    e.errc = 16'(m_errc); e.bitc = 16'(m_bitc);
    e.errc4 = 4'(m_errc4); e.bitc4 = 4'(m_bitc4);
    sb_q.push_back(e);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    chk("sb_locked",     {31'd0, locked},     {31'd0, e.lock});
    chk("sb_err_pulse",  {31'd0, err_pulse},  {31'd0, e.pulse});
    chk("sb_err_count",  {16'd0, err_count},  {16'd0, e.errc});
    chk("sb_bit_count",  {16'd0, bit_count},  {16'd0, e.bitc});
    chk("sb_err_count4", {28'd0, err_count4}, {28'd0, e.errc4});
    chk("sb_bit_count4", {28'd0, bit_count4}, {28'd0, e.bitc4});
  endtask

  // Next PN bit (optionally inverted) as a valid bit.
  task automatic pn(input logic inv, input logic c);
    logic b;
    b  = pn_tbl[ph] ^ inv;
    ph = (ph + 1) % 15;
    step(1'b1, b, c);
  endtask

  task automatic align_window();
    for (int i = 0; i < 16; i++) begin
      if (m_win == 0) break;
      pn(1'b0, 1'b0);
    end
  endtask

  initial begin
    pn_tbl = 15'b111101011001000;
    ph = 0;
    rx.rx_valid = 1'b0; rx.rx_bit = 1'b0; clr_cnt = 1'b0;
    reset = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_locked",    {31'd0, locked},    32'd0);
    chk("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    chk("rst_err_count", {16'd0, err_count}, 32'd0);
    chk("rst_bit_count", {16'd0, bit_count}, 32'd0);
    reset = 1'b1;

    // Clean lock: locked rises right after the 12th bit
    for (int i = 1; i <= 12; i++) begin
      pn(1'b0, 1'b0);
      if (i == 11) chk("lock_not_before_12", {31'd0, locked}, 32'd0);
      if (i == 12) chk("lock_at_12",         {31'd0, locked}, 32'd1);
    end
    repeat (20) pn(1'b0, 1'b0);
    chk("clean_err_count", {16'd0, err_count}, 32'd0);
    chk("clean_bit_count", {16'd0, bit_count}, 32'd20);

    // Single flipped bit
    for (int i = 0; i < 16; i++) begin
      if (m_win == 3) break;
      pn(1'b0, 1'b0);
    end
    pn(1'b1, 1'b0);
    chk("single_pulse",  {31'd0, err_pulse}, 32'd1);
    chk("single_count",  {16'd0, err_count}, 32'd1);
    chk("single_locked", {31'd0, locked},    32'd1);
    pn(1'b0, 1'b0);
    chk("single_pulse_drop", {31'd0, err_pulse}, 32'd0);
    repeat (20) pn(1'b0, 1'b0);
    chk("single_no_more", {16'd0, err_count}, 32'd1);

    // Window reset: 3 errors in each of two consecutive windows
    pn(1'b0, 1'b1);
    align_window();
    for (int k = 0; k < 32; k++) pn(((k % 16) == 2) || ((k % 16) == 6) || ((k % 16) == 10), 1'b0);
    chk("win_locked", {31'd0, locked},    32'd1);
    chk("win_errs",   {16'd0, err_count}, 32'd6);

    // Loss and relock
    align_window();
    for (int k = 0; k < 8; k++) begin
      pn((k == 1) || (k == 3) || (k == 5) || (k == 7), 1'b0);
      if (k == 5) chk("loss_still_locked", {31'd0, locked}, 32'd1);
      if (k == 7) begin
        chk("loss_locked", {31'd0, locked},    32'd0);
        chk("loss_errs",   {16'd0, err_count}, 32'd10);
      end
    end
    for (int i = 1; i <= 12; i++) begin
      pn(1'b0, 1'b0);
      if (i == 11) chk("relock_not_yet", {31'd0, locked}, 32'd0);
      if (i == 12) chk("relock_at_12",   {31'd0, locked}, 32'd1);
    end

    // Saturation of the 4-bit instance
    for (int k = 0; k < 32; k++) pn(((k % 16) == 3) || ((k % 16) == 7) || ((k % 16) == 11), 1'b0);
    chk("sat_main_errs", {16'd0, err_count},  32'd16);
    chk("sat_err4",      {28'd0, err_count4}, 32'd15);
    chk("sat_bit4",      {28'd0, bit_count4}, 32'd15);
    chk("sat_locked",    {31'd0, locked},     32'd1);

    // clr_cnt together with an error
    pn(1'b1, 1'b1);
    chk("clr_pulse",     {31'd0, err_pulse}, 32'd1);
    chk("clr_err_count", {16'd0, err_count}, 32'd0);
    chk("clr_bit_count", {16'd0, bit_count}, 32'd0);
    pn(1'b0, 1'b0);
    pn(1'b0, 1'b0);
    chk("clr_after_bits", {16'd0, bit_count}, 32'd2);

    // Asynchronous reset while locked
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_locked",    {31'd0, locked},    32'd0);
    chk("async_err_count", {16'd0, err_count}, 32'd0);
    chk("async_bit_count", {16'd0, bit_count}, 32'd0);
    chk("async_pulse",     {31'd0, err_pulse}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // All-zero stream must not lock
    repeat (50) step(1'b1, 1'b0, 1'b0);
    chk("zeros_no_lock", {31'd0, locked}, 32'd0);

    // Gapped clean stream from reset locks on the 12th valid bit
    reset = 1'b0;
    #1;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    ph = 0;
    for (int i = 1; i <= 12; i++) begin
      pn(1'b0, 1'b0);
      if (i == 11) chk("gap_not_before_12", {31'd0, locked}, 32'd0);
      if (i == 12) chk("gap_lock_at_12",    {31'd0, locked}, 32'd1);
      step(1'b0, 1'b0, 1'b0);
    end
    repeat (4) begin
      pn(1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    chk("gap_bit_count", {16'd0, bit_count}, 32'd4);
    chk("gap_err_count", {16'd0, err_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
